// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS controller: state encoding,
// opcodes and the aluop codes that aludec expands.
package mips_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ANDIEX  = 4'd10,
    S_ORIEX   = 4'd11,
    S_XORIEX  = 4'd12,
    S_IMMWB   = 4'd13,
    S_JUMP    = 4'd14
  } statetype_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_RTYPE = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;
  localparam logic [2:0] ALU_XOR   = 3'b101;

endpackage

// File: rtl/mainfsm.sv
// Multi-cycle MIPS main controller: Moore FSM driving datapath enables,
// mux selects and the aluop handed to aludec.
//
// state   | meaning
// FETCH   | load IR, PC <= PC+4
// DECODE  | read regs, precompute branch target, dispatch on op
// MEMADR  | ALUOut <= A + SignImm
// MEMRD   | read data memory at ALUOut
// MEMWB   | rt <= Data
// MEMWR   | write B to memory at ALUOut
// EXECUTE | R-type ALU operation
// ALUWB   | rd <= ALUOut
// BRANCH  | compare A,B; conditional PC <= branch target
// ADDIEX  | A + SignImm
// ANDIEX  | A & ZeroImm
// ORIEX   | A | ZeroImm
// XORIEX  | A ^ ZeroImm
// IMMWB   | rt <= ALUOut
// JUMP    | PC <= jump target
module mainfsm
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  output logic       pcwrite,
  output logic       branch,
  output logic       branchne,
  output logic       irwrite,
  output logic       memwrite,
  output logic       regwrite,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       immzext,
  output logic [1:0] pcsrc,
  output logic [2:0] aluop,
  output logic       illegal
);

  statetype_t r_state;
  statetype_t w_next;
  logic       r_bne;

  // beq/bne distinction is captured in DECODE so BRANCH outputs depend on state only
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_FETCH;
      r_bne   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_bne <= (op == OP_BNE);
    end
  end

  always_comb begin
    w_next   = S_FETCH;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    branchne = 1'b0;
    irwrite  = 1'b0;
    memwrite = 1'b0;
    regwrite = 1'b0;
    iord     = 1'b0;
    memtoreg = 1'b0;
    regdst   = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    immzext  = 1'b0;
    pcsrc    = 2'b00;
    aluop    = ALU_ADD;
    illegal  = 1'b0;

    case (r_state)
      S_FETCH: begin
        irwrite = 1'b1;
        pcwrite = 1'b1;
        alusrcb = 2'b01;
        w_next  = S_DECODE;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW:    w_next = S_MEMADR;
          OP_RTYPE:        w_next = S_EXECUTE;
          OP_BEQ, OP_BNE:  w_next = S_BRANCH;
          OP_ADDI:         w_next = S_ADDIEX;
          OP_ANDI:         w_next = S_ANDIEX;
          OP_ORI:          w_next = S_ORIEX;
          OP_XORI:         w_next = S_XORIEX;
          OP_J:            w_next = S_JUMP;
          default: begin
            w_next  = S_FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        w_next  = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord   = 1'b1;
        w_next = S_MEMWB;
      end
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      S_EXECUTE: begin
        alusrca = 1'b1;
        aluop   = ALU_RTYPE;
        w_next  = S_ALUWB;
      end
      S_ALUWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
      end
      S_BRANCH: begin
        alusrca  = 1'b1;
        aluop    = ALU_SUB;
        pcsrc    = 2'b01;
        branch   = ~r_bne;
        branchne = r_bne;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        w_next  = S_IMMWB;
      end
      S_ANDIEX, S_ORIEX, S_XORIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        immzext = 1'b1;
        aluop   = (r_state == S_ANDIEX) ? ALU_AND :
                  (r_state == S_ORIEX)  ? ALU_OR  : ALU_XOR;
        w_next  = S_IMMWB;
      end
      S_IMMWB: begin
        regwrite = 1'b1;
      end
      S_JUMP: begin
        pcwrite = 1'b1;
        pcsrc   = 2'b10;
      end
      default: w_next = S_FETCH;
    endcase

    // reset gates every strobe combinationally, not just from the next edge
    if (!reset) begin
      pcwrite  = 1'b0;
      branch   = 1'b0;
      branchne = 1'b0;
      irwrite  = 1'b0;
      memwrite = 1'b0;
      regwrite = 1'b0;
      iord     = 1'b0;
      memtoreg = 1'b0;
      regdst   = 1'b0;
      alusrca  = 1'b0;
      alusrcb  = 2'b00;
      immzext  = 1'b0;
      pcsrc    = 2'b00;
      aluop    = ALU_ADD;
      illegal  = 1'b0;
    end
  end

endmodule

// File: tb/tb_mainfsm.sv
// Randomized bench for mainfsm: each instruction is expanded into its expected
// per-cycle output sequence and compared cycle by cycle.
module tb_mainfsm;

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic       pcwrite, branch, branchne, irwrite, memwrite, regwrite;
  logic       iord, memtoreg, regdst, alusrca, immzext, illegal;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] aluop;

  typedef struct packed {
    logic       pcwrite;
    logic       branch;
    logic       branchne;
    logic       irwrite;
    logic       memwrite;
    logic       regwrite;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       immzext;
    logic [1:0] pcsrc;
    logic [2:0] aluop;
    logic       illegal;
  } outs_t;

  int    n_checks = 0;
  int    n_errors = 0;
  outs_t exp_q[$];

  mainfsm dut (
    .clk(clk), .reset(reset), .op(op),
    .pcwrite(pcwrite), .branch(branch), .branchne(branchne),
    .irwrite(irwrite), .memwrite(memwrite), .regwrite(regwrite),
    .iord(iord), .memtoreg(memtoreg), .regdst(regdst),
    .alusrca(alusrca), .alusrcb(alusrcb), .immzext(immzext),
    .pcsrc(pcsrc), .aluop(aluop), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic outs_t observed();
    outs_t o;
    o.pcwrite  = pcwrite;  o.branch   = branch;   o.branchne = branchne;
    o.irwrite  = irwrite;  o.memwrite = memwrite; o.regwrite = regwrite;
    o.iord     = iord;     o.memtoreg = memtoreg; o.regdst   = regdst;
    o.alusrca  = alusrca;  o.alusrcb  = alusrcb;  o.immzext  = immzext;
    o.pcsrc    = pcsrc;    o.aluop    = aluop;    o.illegal  = illegal;
    return o;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%05h exp=%05h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Sample mid-cycle, then return 1 time unit after the next rising edge.
  task automatic cyc_check(input string tag, input outs_t exp);
    @(negedge clk);
    check(tag, 32'(observed()), 32'(exp));
    @(posedge clk);
    #1;
  endtask

  // Reference: the cycle-by-cycle output sequence an instruction should produce.
  task automatic build_expected(input logic [5:0] o);
    outs_t w;
    exp_q.delete();
    w = '0; w.irwrite = 1; w.pcwrite = 1; w.alusrcb = 2'b01;
    exp_q.push_back(w);
    w = '0; w.alusrcb = 2'b11;
    case (o)
      6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101,
      6'b001000, 6'b001100, 6'b001101, 6'b001110, 6'b000010: ;
      default: w.illegal = 1;
    endcase
    exp_q.push_back(w);
    case (o)
      6'b100011: begin
        w = '0; w.alusrca = 1; w.alusrcb = 2'b10; exp_q.push_back(w);
        w = '0; w.iord = 1; exp_q.push_back(w);
        w = '0; w.regwrite = 1; w.memtoreg = 1; exp_q.push_back(w);
      end
      6'b101011: begin
        w = '0; w.alusrca = 1; w.alusrcb = 2'b10; exp_q.push_back(w);
        w = '0; w.iord = 1; w.memwrite = 1; exp_q.push_back(w);
      end
      6'b000000: begin
        w = '0; w.alusrca = 1; w.aluop = 3'b010; exp_q.push_back(w);
        w = '0; w.regwrite = 1; w.regdst = 1; exp_q.push_back(w);
      end
      6'b000100, 6'b000101: begin
        w = '0; w.alusrca = 1; w.aluop = 3'b001; w.pcsrc = 2'b01;
        w.branch = (o == 6'b000100); w.branchne = (o == 6'b000101);
        exp_q.push_back(w);
      end
      6'b001000, 6'b001100, 6'b001101, 6'b001110: begin
        w = '0; w.alusrca = 1; w.alusrcb = 2'b10;
        w.aluop   = (o == 6'b001000) ? 3'b000 : (o == 6'b001100) ? 3'b011 :
                    (o == 6'b001101) ? 3'b100 : 3'b101;
        w.immzext = (o != 6'b001000);
        exp_q.push_back(w);
        w = '0; w.regwrite = 1; exp_q.push_back(w);
      end
      6'b000010: begin
        w = '0; w.pcwrite = 1; w.pcsrc = 2'b10; exp_q.push_back(w);
      end
      default: ;
    endcase
  endtask

  // Runs one instruction; rst_at >= 1 asserts reset in that cycle for 2 cycles.
  task automatic run_instr(input logic [5:0] o, input int rst_at);
    string tag;
    build_expected(o);
    op = 6'($urandom_range(0, 63));
    cyc_check($sformatf("fetch op=%b", o), exp_q[0]);
    op = o;
    for (int i = 1; i < exp_q.size(); i++) begin
      if (i == rst_at) begin
        reset = 1'b0;
        cyc_check($sformatf("rst_mid op=%b c%0d", o, i), '0);
        cyc_check($sformatf("rst_hold op=%b", o), '0);
        reset = 1'b1;
        return;
      end
      tag = $sformatf("op=%b c%0d", o, i);
      cyc_check(tag, exp_q[i]);
    end
  endtask

  logic [5:0] legal_ops [10] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101,
                                 6'b001000, 6'b001100, 6'b001101, 6'b001110, 6'b000010};

  initial begin
    logic [5:0] o;
    int         rst_at;
    reset = 1'b0;
    op    = 6'b000010;
    #1;
    for (int i = 0; i < 3; i++) cyc_check("reset_hold", '0);
    reset = 1'b1;

    run_instr(6'b100011, -1);
    run_instr(6'b000000, -1);
    run_instr(6'b001101, -1);
    run_instr(6'b000100, -1);
    run_instr(6'b000101, -1);
    run_instr(6'b111111, -1);
    run_instr(6'b101011, 2);

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 4) == 0) o = 6'($urandom_range(0, 63));
      else                           o = legal_ops[$urandom_range(0, 9)];
      build_expected(o);
      rst_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 4)) : -1;
      run_instr(o, rst_at);
    end

    build_expected(6'b000000);
    cyc_check("final_fetch", exp_q[0]);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mainfsm.md
# mainfsm

Multi-cycle MIPS main controller: a Moore state machine that steps each instruction through fetch, decode, execute, memory and writeback, and drives every datapath enable and mux select. It sits directly upstream of the ALU decoder, supplying the 3-bit `aluop` that `aludec` expands (with `funct`) into `alucontrol`. It also supplies the PC-write, branch, memory and register-file strobes to the datapath.

## Interface
- No parameters; opcodes, `aluop` codes and the state encoding come from the shared package.
- `clk` in 1: single system clock, rising edge.
- `reset` in 1: synchronous, active-low; sampled on `clk` rising edge.
- `op` in 6: instruction-register opcode field `instr[31:26]`; stable from the cycle after FETCH.
- `pcwrite` out 1: unconditional PC write.
- `branch` out 1: PC write if ALU `zero`=1 (beq).
- `branchne` out 1: PC write if ALU `zero`=0 (bne).
- `irwrite` out 1: instruction-register load.
- `memwrite` out 1: memory write strobe.
- `regwrite` out 1: register-file write.
- `iord` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `memtoreg` out 1: writeback select; 1 = Data register.
- `regdst` out 1: destination select; 1 = rd, 0 = rt.
- `alusrca` out 1: ALU A select; 0 = PC, 1 = A register.
- `alusrcb` out 2: ALU B select; 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2.
- `immzext` out 1: zero-extend the immediate (andi/ori/xori).
- `pcsrc` out 2: PC source; 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- `aluop` out 3: 000 add, 001 sub, 010 R-type, 011 and, 100 or, 101 xor; 110/111 never driven.
- `illegal` out 1: DECODE saw an unsupported opcode.

## Operation
- Opcodes: lw 100011, sw 101011, R-type 000000, beq 000100, bne 000101, addi 001000, andi 001100, ori 001101, xori 001110, j 000010.
- Moore outputs: every output is a pure function of the state, except `illegal`, which is a function of the state and `op`. Any output not listed for a state is 0.
- States, their outputs, and the next state:
  - FETCH: `irwrite`=1, `pcwrite`=1, `alusrcb`=01, `aluop`=000 -> DECODE.
  - DECODE: `alusrcb`=11, `aluop`=000. Next state by `op`:
    - lw/sw -> MEMADR
    - R-type -> EXECUTE
    - beq/bne -> BRANCH
    - addi -> ADDIEX
    - andi -> ANDIEX
    - ori -> ORIEX
    - xori -> XORIEX
    - j -> JUMP
    - anything else -> FETCH, with `illegal`=1 for that cycle.
  - MEMADR: `alusrca`=1, `alusrcb`=10, `aluop`=000 -> MEMRD if `op`=lw, else MEMWR.
  - MEMRD: `iord`=1 -> MEMWB.
  - MEMWB: `regwrite`=1, `memtoreg`=1, `regdst`=0 -> FETCH.
  - MEMWR: `iord`=1, `memwrite`=1 -> FETCH.
  - EXECUTE: `alusrca`=1, `alusrcb`=00, `aluop`=010 -> ALUWB.
  - ALUWB: `regwrite`=1, `regdst`=1, `memtoreg`=0 -> FETCH.
  - BRANCH: `alusrca`=1, `alusrcb`=00, `aluop`=001, `pcsrc`=01; `branch`=1 for beq, `branchne`=1 for bne -> FETCH.
  - ADDIEX: `alusrca`=1, `alusrcb`=10, `aluop`=000 -> IMMWB.
  - ANDIEX / ORIEX / XORIEX: same as ADDIEX but `aluop`=011 / 100 / 101, and `immzext`=1 -> IMMWB.
  - IMMWB: `regwrite`=1, `regdst`=0, `memtoreg`=0 -> FETCH.
  - JUMP: `pcwrite`=1, `pcsrc`=10 -> FETCH.
- Unreachable state encodings -> FETCH on the next edge, with all outputs 0 while in them.

## Timing
- State register updates on the rising edge of `clk`. With `reset`=0 at an edge, the next state is FETCH regardless of the current state or `op`; this includes mid-instruction.
- While `reset`=0 (combinational gate), all outputs are forced to 0, including `pcwrite`, `irwrite`, `memwrite`, `regwrite` and `illegal`. The first FETCH strobes occur in the first cycle after `reset` returns to 1.
- Cycles per instruction, counted from FETCH inclusive:
  - lw: 5
  - sw, R-type, addi, andi, ori, xori: 4
  - beq, bne, j: 3
  - illegal: 2
- Strobes are single-cycle: `memwrite`, `regwrite` and `illegal` are never high for 2 consecutive cycles within one instruction.
- `op` is sampled in DECODE and MEMADR only. It may change arbitrarily in FETCH without effect.

## Structure
- Shared package `mips_pkg` holds:
  - the state enum `statetype_t` (4-bit encoding);
  - opcode localparams (`OP_LW` … `OP_J`);
  - `aluop` localparams (`ALU_ADD`=000 … `ALU_XOR`=101), shared with `aludec`.
- One module: a state register plus one combinational next-state/output block. No sub-module; the output decode is too small to justify one.

## Test plan
- Reset: hold `reset`=0 for 3 cycles with `op`=j -> all outputs 0. Release -> FETCH with `pcwrite`=`irwrite`=1, `alusrcb`=01, `aluop`=000.
- lw (`op`=100011) -> state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB. `regwrite`=`memtoreg`=1 in cycle 5 only. Back in FETCH at cycle 6.
- R-type, then ori (001101) -> `aluop` is 010 in EXECUTE, then 100 with `immzext`=1 in ORIEX. `regdst` is 1 in ALUWB and 0 in IMMWB.
- beq, then bne -> BRANCH has `aluop`=001, `pcsrc`=01. `branch`=1 for beq and `branchne`=1 for bne, never both.
- Illegal `op`=111111 -> `illegal`=1 in DECODE for one cycle, FETCH next. No `regwrite`/`memwrite` anywhere in the instruction.
- Reset mid-sw: assert `reset`=0 during MEMADR -> `memwrite` never asserts; state is FETCH after release.
